// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM write-side arbiter.
package vram_pkg;

  localparam int LINE_W    = 640;
  localparam int ADDR_W    = 9;
  localparam int NUM_LINES = 480;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic; the priority pointer is kept by the parent.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // rr_ptr_i=0 favours requester 0 on contention, 1 favours requester 1.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = rr_ptr_i ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// VRAM port-A owner: round-robin line writes from two requesters plus a clear sweep.
// Optional macro VRAM_WRITE_VBLANK_ONLY_EN restricts idle grants to vblank=1.
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter logic FILL_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              clr_n,
`ifdef VRAM_WRITE_VBLANK_ONLY_EN
  input  logic              vblank,
`endif
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [LINE_W-1:0] r0_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [LINE_W-1:0] r1_data,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [LINE_W-1:0] vram_din,
  output logic              drop_err
);

  localparam addr_t LAST_LINE = addr_t'(NUM_LINES - 1);

  state_e state_q, state_d;
  addr_t  clr_cnt_q, clr_cnt_d;
  logic   rr_ptr_q, rr_ptr_d;
  logic   we_q, we_d;
  addr_t  addr_q, addr_d;
  line_t  din_q, din_d;
  logic   busy_q, busy_d;
  logic   drop_q, drop_d;

  logic   grant_en;
  logic [1:0] gnt;
  addr_t  sel_addr;
  line_t  sel_data;

`ifdef VRAM_WRITE_VBLANK_ONLY_EN
  assign grant_en = (state_q == IDLE) && !clear_req && vblank;
`else
  assign grant_en = (state_q == IDLE) && !clear_req;
`endif

  rr_arb2 u_arb (
    .req_i   ({r1_valid, r0_valid}),
    .rr_ptr_i(rr_ptr_q),
    .en_i    (grant_en),
    .gnt_o   (gnt)
  );

  assign r0_ready = gnt[0];
  assign r1_ready = gnt[1];
  assign sel_addr = gnt[1] ? r1_addr : r0_addr;
  assign sel_data = gnt[1] ? r1_data : r0_data;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    busy_d    = 1'b0;
    drop_d    = drop_q;
    case (state_q)
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = clr_cnt_q;
        din_d  = {LINE_W{FILL_BIT}};
        busy_d = 1'b1;
        if (clr_cnt_q == LAST_LINE) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + addr_t'(1);
        end
      end
      IDLE: begin
        if (clear_req) begin
          clr_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = CLEAR;
        end else if (|gnt) begin
          // Pointer moves to the requester that was not just served.
          rr_ptr_d = gnt[0];
          if (sel_addr <= LAST_LINE) begin
            we_d   = 1'b1;
            addr_d = sel_addr;
            din_d  = sel_data;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rr_ptr_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      busy_q    <= 1'b1;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  assign vram_we    = we_q;
  assign vram_addr  = addr_q;
  assign vram_din   = din_q;
  assign clear_busy = busy_q;
  assign drop_err   = drop_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: a transaction-level model predicts grants and VRAM writes.
module tb_vram_write_arbiter;
  import vram_pkg::*;

  logic  clk = 1'b0;
  logic  clr_n = 1'b1;
  logic  clear_req = 1'b0;
  logic  r0_valid = 1'b0, r1_valid = 1'b0;
  addr_t r0_addr = '0, r1_addr = '0;
  line_t r0_data = '0, r1_data = '0;
  logic  clear_busy, r0_ready, r1_ready, vram_we, drop_err;
  addr_t vram_addr;
  line_t vram_din;
`ifdef VRAM_WRITE_VBLANK_ONLY_EN
  logic  vblank = 1'b1;
`endif

  vram_write_arbiter dut (
    .clk       (clk),
    .clr_n     (clr_n),
`ifdef VRAM_WRITE_VBLANK_ONLY_EN
    .vblank    (vblank),
`endif
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_addr   (r0_addr),
    .r0_data   (r0_data),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_addr   (r1_addr),
    .r1_data   (r1_data),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_din  (vram_din),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    addr;
    line_t data;
  } wr_t;

  typedef struct {
    int    addr;
    line_t data;
  } txn_t;

  wr_t  expQ[$];
  txn_t r0Q[$];
  txn_t r1Q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit monOn = 1'b0;

  // Model state: lines still to sweep, next sweep line, last requester served, sticky drop, busy flag.
  int mClearLeft = 0;
  int mLine = 0;
  int mLast = 1;
  bit mDrop = 1'b0;
  bit mBusy = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Every cycle either a predicted write is due, or the write enable must be low.
  always @(negedge clk) begin
    if (monOn && clr_n) begin
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("write_we", vram_we, 1'b1);
        checkOutput("write_addr", vram_addr, e.addr);
        checkOutput("write_data", vram_din, e.data);
      end else begin
        checkOutput("idle_we", vram_we, 1'b0);
      end
    end
  end

  function automatic txn_t randTxn(input int lo, input int hi);
    txn_t t;
    t.addr = $urandom_range(hi, lo);
    for (int k = 0; k < LINE_W / 32; k++) t.data[k*32 +: 32] = $urandom;
    return t;
  endfunction

  function automatic txn_t fixedTxn(input int addr);
    txn_t t;
    t = randTxn(0, 0);
    t.addr = addr;
    return t;
  endfunction

  task automatic applyStimulus(input bit clr);
    @(posedge clk);
    #1;
    clear_req = clr;
    r0_valid  = (r0Q.size() > 0);
    r1_valid  = (r1Q.size() > 0);
    if (r0_valid) begin
      r0_addr = addr_t'(r0Q[0].addr);
      r0_data = r0Q[0].data;
    end
    if (r1_valid) begin
      r1_addr = addr_t'(r1Q[0].addr);
      r1_data = r1Q[0].data;
    end
    #1;
  endtask

  task automatic serve(input txn_t t);
    wr_t w;
    if (t.addr < NUM_LINES) begin
      w.cyc  = cyc + 1;
      w.addr = t.addr;
      w.data = t.data;
      expQ.push_back(w);
    end else begin
      mDrop = 1'b1;
    end
  endtask

  task automatic modelStep();
    bit g0 = 1'b0;
    bit g1 = 1'b0;
    bit nextBusy = 1'b0;
    wr_t w;
    checkOutput("clear_busy", clear_busy, mBusy);
    checkOutput("drop_err", drop_err, mDrop);
    if (mClearLeft > 0) begin
      w.cyc  = cyc + 1;
      w.addr = mLine;
      w.data = '0;
      expQ.push_back(w);
      mLine++;
      mClearLeft--;
      nextBusy = 1'b1;
    end else if (clear_req) begin
      mClearLeft = NUM_LINES;
      mLine = 0;
      nextBusy = 1'b1;
    end else begin
      if (r0_valid && r1_valid) begin
        g0 = (mLast == 1);
        g1 = (mLast == 0);
      end else begin
        g0 = r0_valid;
        g1 = r1_valid;
      end
    end
    checkOutput("r0_ready", r0_ready, g0);
    checkOutput("r1_ready", r1_ready, g1);
    if (g0) begin
      serve(r0Q.pop_front());
      mLast = 0;
    end
    if (g1) begin
      serve(r1Q.pop_front());
      mLast = 1;
    end
    mBusy = nextBusy;
  endtask

  task automatic runCycle(input bit clr);
    applyStimulus(clr);
    modelStep();
  endtask

  task automatic resetPulse();
    @(posedge clk);
    #1;
    clr_n = 1'b0;
    clear_req = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    #1;
    checkOutput("rst_we", vram_we, 1'b0);
    checkOutput("rst_addr", vram_addr, '0);
    checkOutput("rst_din", vram_din, '0);
    checkOutput("rst_r0_ready", r0_ready, 1'b0);
    checkOutput("rst_r1_ready", r1_ready, 1'b0);
    checkOutput("rst_busy", clear_busy, 1'b1);
    checkOutput("rst_drop", drop_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    r0Q.delete();
    r1Q.delete();
    expQ.delete();
    mClearLeft = NUM_LINES;
    mLine = 0;
    mLast = 1;
    mDrop = 1'b0;
    mBusy = 1'b1;
    clr_n = 1'b1;
    monOn = 1'b1;
    #1;
    modelStep();
  endtask

  initial begin
    resetPulse();
    repeat (485) runCycle(1'b0);

    for (int i = 0; i < 4; i++) begin
      r0Q.push_back(fixedTxn(5));
      r1Q.push_back(fixedTxn(6));
    end
    repeat (10) runCycle(1'b0);

    for (int a = 10; a <= 12; a++) r0Q.push_back(fixedTxn(a));
    repeat (6) runCycle(1'b0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(2, 0) != 0 && r0Q.size() < 4) r0Q.push_back(randTxn(0, NUM_LINES - 1));
      if ($urandom_range(2, 0) != 0 && r1Q.size() < 4) r1Q.push_back(randTxn(0, NUM_LINES - 1));
      runCycle(1'b0);
    end

    for (int i = 0; i < 3; i++) begin
      r0Q.push_back(randTxn(0, NUM_LINES - 1));
      r1Q.push_back(randTxn(0, NUM_LINES - 1));
    end
    runCycle(1'b1);
    for (int i = 0; i < 500; i++) begin
      runCycle(($urandom_range(3, 0) == 0) && (mClearLeft > 0));
    end

    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(1, 0) != 0 && r0Q.size() < 4) r0Q.push_back(randTxn(0, NUM_LINES - 1));
      if ($urandom_range(1, 0) != 0 && r1Q.size() < 4) r1Q.push_back(randTxn(0, NUM_LINES - 1));
      runCycle(1'b0);
    end
    repeat (12) runCycle(1'b0);

    r1Q.push_back(fixedTxn(NUM_LINES));
    r0Q.push_back(fixedTxn(NUM_LINES - 1));
    r1Q.push_back(fixedTxn(511));
    repeat (8) runCycle(1'b0);

    resetPulse();
    repeat (199) runCycle(1'b0);
    resetPulse();
    repeat (485) runCycle(1'b0);

    r0Q.push_back(fixedTxn(0));
    r1Q.push_back(fixedTxn(NUM_LINES - 1));
    repeat (5) runCycle(1'b0);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
